// File: rtl/charge_injection_burst_gen_if.sv
// Bundle of the charge-injection burst generator's control and status signals.
// master: fast-command decoder side (drives timing fields and the command).
// slave:  the burst generator itself (drives pulse and status).
interface charge_injection_burst_gen_if #(
  parameter int PHASE_BITS   = 5,
  parameter int WIDTH_BITS   = 6,
  parameter int COUNT_BITS   = 8,
  parameter int SPACING_BITS = 8
);
  logic                    alignStrobe;
  logic                    chargeInjectionCmd;
  logic [PHASE_BITS-1:0]   delay;
  logic [WIDTH_BITS-1:0]   width;
  logic [COUNT_BITS-1:0]   burstCount;
  logic [SPACING_BITS-1:0] spacing;
  logic                    pulse;
  logic                    busy;
  logic                    done;
  logic                    alignError;

  modport master (
    output alignStrobe, chargeInjectionCmd, delay, width, burstCount, spacing,
    input  pulse, busy, done, alignError
  );

  modport slave (
    input  alignStrobe, chargeInjectionCmd, delay, width, burstCount, spacing,
    output pulse, busy, done, alignError
  );
endinterface

// File: rtl/charge_injection_burst_gen.sv
// Charge-injection burst generator running on clk1280.
// Tracks clk40 phase with a counter realigned by alignStrobe, and on a command
// rising edge emits a burst of pulses at a fine phase, width and BX spacing
// latched at the start of the burst. burstCount==0 runs until the command drops.
// Optional alignment checker enabled by defining CI_ALIGN_CHECK_EN; without it
// alignError is tied low and no checker registers exist.
module charge_injection_burst_gen #(
  parameter int PHASE_BITS   = 5,
  parameter int WIDTH_BITS   = 6,
  parameter int COUNT_BITS   = 8,
  parameter int SPACING_BITS = 8
) (
  input logic clk1280,
  input logic reset,
  charge_injection_burst_gen_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HIGH = 2'd3;

  localparam logic [PHASE_BITS-1:0]   PHASE_MAX   = '1;
  localparam logic [PHASE_BITS-1:0]   PHASE_ONE   = 1;
  localparam logic [WIDTH_BITS-1:0]   WIDTH_ONE   = 1;
  localparam logic [COUNT_BITS-1:0]   COUNT_ONE   = 1;
  localparam logic [SPACING_BITS-1:0] SPACING_ONE = 1;
  localparam logic [SPACING_BITS:0]   BX_ONE      = 1;
  localparam logic [SPACING_BITS:0]   BX_SAT      = '1;

  logic [PHASE_BITS-1:0]   phase_reg;
  logic                    cmd_d_reg;
  logic [1:0]              state_reg;
  logic [PHASE_BITS-1:0]   delay_reg;
  logic [WIDTH_BITS-1:0]   width_reg;
  logic [COUNT_BITS-1:0]   count_reg;
  logic [SPACING_BITS-1:0] spacing_reg;
  logic [COUNT_BITS-1:0]   pulses_done_reg;
  logic [WIDTH_BITS-1:0]   width_cnt_reg;
  logic [SPACING_BITS:0]   bx_since_reg;
  logic                    pulse_reg;
  logic                    done_reg;

  logic                    start;
  logic                    at_max;
  logic                    at_slot;
  logic                    bx_ready;
  logic                    cont_mode;
  logic                    stop_req;
  logic [SPACING_BITS:0]   bx_inc;

  assign start     = bus.chargeInjectionCmd & ~cmd_d_reg;
  assign at_max    = (phase_reg == PHASE_MAX);
  assign at_slot   = (phase_reg == delay_reg);
  assign bx_ready  = (bx_since_reg >= {1'b0, spacing_reg});
  assign cont_mode = (count_reg == '0);
  assign stop_req  = cont_mode & ~bus.chargeInjectionCmd;
  // BX counter saturates so very long waits cannot wrap back below spacing.
  assign bx_inc    = (bx_since_reg == BX_SAT) ? bx_since_reg : bx_since_reg + BX_ONE;

  // Phase counter: strobe cycle is phase 0, so the next cycle is phase 1.
  always_ff @(posedge clk1280 or posedge reset) begin
    if (reset) phase_reg <= '0;
    else if (bus.alignStrobe) phase_reg <= PHASE_ONE;
    else phase_reg <= phase_reg + PHASE_ONE;
  end

  // Command history; resets high so a command held across reset cannot start a burst.
  always_ff @(posedge clk1280 or posedge reset) begin
    if (reset) cmd_d_reg <= 1'b1;
    else cmd_d_reg <= bus.chargeInjectionCmd;
  end

  // Burst sequencer: latch settings, arm to the BX boundary, then pulse/wait per slot.
  always_ff @(posedge clk1280 or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      delay_reg       <= '0;
      width_reg       <= '0;
      count_reg       <= '0;
      spacing_reg     <= '0;
      pulses_done_reg <= '0;
      width_cnt_reg   <= '0;
      bx_since_reg    <= '0;
      pulse_reg       <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            delay_reg       <= bus.delay;
            width_reg       <= (bus.width == '0) ? WIDTH_ONE : bus.width;
            count_reg       <= bus.burstCount;
            spacing_reg     <= (bus.spacing == '0) ? SPACING_ONE : bus.spacing;
            pulses_done_reg <= '0;
            state_reg       <= ARM;
          end
        end
        ARM: begin
          // Pre-loading spacing makes the first slot of the next BX eligible.
          if (at_max) begin
            bx_since_reg <= {1'b0, spacing_reg};
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          // Stopping wins over a coinciding slot so done never meets a rising pulse.
          if (stop_req) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end else if (at_slot && bx_ready) begin
            pulse_reg     <= 1'b1;
            width_cnt_reg <= width_reg;
            // A slot on the last phase also closes this BX, so count it now.
            bx_since_reg  <= at_max ? BX_ONE : '0;
            state_reg     <= HIGH;
          end else if (at_max) begin
            bx_since_reg <= bx_inc;
          end
        end
        HIGH: begin
          width_cnt_reg <= width_cnt_reg - WIDTH_ONE;
          if (at_max) bx_since_reg <= bx_inc;
          if (width_cnt_reg == WIDTH_ONE) begin
            pulse_reg       <= 1'b0;
            pulses_done_reg <= pulses_done_reg + COUNT_ONE;
            if (stop_req || (!cont_mode && (pulses_done_reg + COUNT_ONE == count_reg))) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pulse = pulse_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.done  = done_reg;

`ifdef CI_ALIGN_CHECK_EN
  logic seen_strobe_reg;
  logic align_error_reg;

  // Sticky alignment check: any strobe after the first must land on phase 0.
  always_ff @(posedge clk1280 or posedge reset) begin
    if (reset) begin
      seen_strobe_reg <= 1'b0;
      align_error_reg <= 1'b0;
    end else if (bus.alignStrobe) begin
      seen_strobe_reg <= 1'b1;
      if (seen_strobe_reg && (phase_reg != '0)) align_error_reg <= 1'b1;
    end
  end

  assign bus.alignError = align_error_reg;
`else
  assign bus.alignError = 1'b0;
`endif
endmodule
